// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush scheduler and multiply/divide busy sequencer for the 5-stage pipeline
// Optional stall statistics counters: define PIPE_STALL_STATS_EN.
module pipe_hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic [1:0]  D_tuse_rs,
  input  logic [1:0]  D_tuse_rt,
  input  logic        D_is_md,
  input  logic        D_eret,
  input  logic [4:0]  E_wa,
  input  logic [1:0]  E_tnew,
  input  logic [4:0]  M_wa,
  input  logic [1:0]  M_tnew,
  input  logic        E_md_start,
  input  logic        E_md_is_div,
  input  logic        E_mtc0_epc,
  input  logic        M_mtc0_epc,
  input  logic        int_exc_req,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_flush,
  output logic        D_null_slot,
  output logic        md_busy,
`ifdef PIPE_STALL_STATS_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt,
`endif
  output logic        stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_t;

  md_state_t     md_state, md_state_nxt;
  logic [CW-1:0] md_cnt, md_cnt_nxt;

  logic stall_rs, stall_rt, stall_md, stall_eret, stall_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_state <= MD_IDLE;
      md_cnt   <= '0;
    end else begin
      md_state <= md_state_nxt;
      md_cnt   <= md_cnt_nxt;
    end
  end

  // A start while busy cannot occur: stall_md holds the issuing instruction in D.
  always_comb begin
    md_state_nxt = md_state;
    md_cnt_nxt   = md_cnt;
    case (md_state)
      MD_IDLE: begin
        if (E_md_start) begin
          md_state_nxt = MD_BUSY;
          md_cnt_nxt   = E_md_is_div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MD_BUSY: begin
        if (md_cnt == '0) md_state_nxt = MD_IDLE;
        else              md_cnt_nxt   = md_cnt - 1'b1;
      end
      default: md_state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (md_state == MD_BUSY);
  end

  assign stall_rs   = (D_rs != 5'd0) &&
                      ((D_rs == E_wa && E_tnew > D_tuse_rs) || (D_rs == M_wa && M_tnew > D_tuse_rs));
  assign stall_rt   = (D_rt != 5'd0) &&
                      ((D_rt == E_wa && E_tnew > D_tuse_rt) || (D_rt == M_wa && M_tnew > D_tuse_rt));
  assign stall_md   = D_is_md && (md_busy || E_md_start);
  assign stall_eret = D_eret && (E_mtc0_epc || M_mtc0_epc);
  assign stall_raw  = stall_rs | stall_rt | stall_md | stall_eret;

  // Exceptions override any hazard: the pipeline redirects and D/E is squashed.
  always_comb begin
    PC_en       = 1'b1;
    D_en        = 1'b1;
    E_flush     = 1'b0;
    D_null_slot = 1'b0;
    stall       = 1'b0;
    if (!reset) begin
      if (int_exc_req) begin
        E_flush = 1'b1;
      end else if (stall_raw) begin
        PC_en   = 1'b0;
        D_en    = 1'b0;
        E_flush = 1'b1;
        stall   = 1'b1;
      end else begin
        D_null_slot = D_eret;
      end
    end
  end

`ifdef PIPE_STALL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else if (!int_exc_req) begin
      if (stall)    stall_cnt    <= stall_cnt + 32'd1;
      if (stall_md) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
